// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer
//
// Runs the playfield line-clear sequence after each piece lock and computes the
// attack that lock produces.
//   IDLE   : wait for lock_valid; capture the full-row mask and the T-spin flag.
//   ANIM   : hold for CLEAR_DELAY cycles so the clear animation can play.
//   SHIFT  : issue one row-collapse command per full row, lowest index first,
//            over a valid/ready handshake.
//   REPORT : one-cycle done pulse carrying the per-lock results.
// The per-lock results and the combo/B2B state are all registered on the edge
// that enters REPORT. As a result, b2b_active already shows the updated value
// during done, while combo_count shows the streak as it stood before this lock.
//
// Ports
//   clk, rst_l            clock, asynchronous active-low reset
//   game_start            synchronous abort; also zeroes the combo and B2B state
//   lock_valid, tspin     single-cycle lock event and its T-spin qualifier
//   lines_full            per-row full flags, sampled only on an accepted lock
//   shift_ready           playfield accepts the current shift command
//   busy                  high from the accepted lock through the done cycle
//   shift_valid/shift_row row-collapse command to the playfield
//   done                  single-cycle pulse: the result outputs below are valid
//   lines_this_lock       rows cleared by this lock, saturated at 4
//   lines_sent            garbage lines generated by this lock
//   combo_count           clearing-lock streak before this lock (saturates at 31)
//   b2b_active            back-to-back bonus is armed
module line_clear_sequencer #(
  parameter int PLAYFIELD_ROWS = 20,
  parameter int CLEAR_DELAY    = 30
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      game_start,
  input  logic                      lock_valid,
  input  logic                      tspin,
  input  logic [PLAYFIELD_ROWS-1:0] lines_full,
  input  logic                      shift_ready,
  output logic                      busy,
  output logic                      shift_valid,
  output logic [4:0]                shift_row,
  output logic                      done,
  output logic [2:0]                lines_this_lock,
  output logic [3:0]                lines_sent,
  output logic [4:0]                combo_count,
  output logic                      b2b_active
);

  // The counter only needs to hold CLEAR_DELAY-1.
  localparam int CNT_W = (CLEAR_DELAY > 1) ? $clog2(CLEAR_DELAY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ANIM,
    S_SHIFT,
    S_REPORT
  } state_e;

  state_e                    state_q;
  logic [PLAYFIELD_ROWS-1:0] mask_q;
  logic                      tspin_q;
  logic [2:0]                n_q;         // saturated row count of mask_q
  logic [CNT_W-1:0]          cnt_q;
  logic                      busy_q;
  logic                      shift_valid_q;
  logic [4:0]                shift_row_q;
  logic                      done_q;
  logic [2:0]                lines_this_lock_q;
  logic [3:0]                lines_sent_q;
  logic [4:0]                combo_count_q;  // streak shown to the outside
  logic [4:0]                combo_q;        // live streak, already updated
  logic                      b2b_q;

  // Combinational next-state helpers.
  logic [PLAYFIELD_ROWS-1:0] mask_d;      // mask after the current handshake
  logic                      handshake;
  logic                      rpt_fire;    // this edge enters REPORT
  logic [2:0]                rpt_n;
  logic                      rpt_ts;
  logic                      rpt_difficult;
  logic [3:0]                rpt_sent;

  // Returns the lowest-index set row. Deleting a row moves only the rows above
  // it, so handling rows in ascending order keeps the remaining indices valid.
  function automatic logic [4:0] lowest_row(input logic [PLAYFIELD_ROWS-1:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = PLAYFIELD_ROWS - 1; i >= 0; i--) begin
      if (m[i]) r = 5'(i);
    end
    return r;
  endfunction

  // Counts the full rows, saturating at 4.
  function automatic logic [2:0] sat_count(input logic [PLAYFIELD_ROWS-1:0] m);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < PLAYFIELD_ROWS; i++) begin
      c = c + 6'(m[i]);
    end
    return (c > 6'd4) ? 3'd4 : c[2:0];
  endfunction

  // Attack = base + B2B bonus + combo bonus.
  function automatic logic [3:0] attack(input logic [2:0] n, input logic ts,
                                        input logic b2b, input logic [4:0] combo);
    logic [3:0] base;
    logic [3:0] combo_bonus;
    logic       difficult;
    if (ts) begin
      base = {n, 1'b0};
    end else begin
      case (n)
        3'd2:    base = 4'd1;
        3'd3:    base = 4'd2;
        3'd4:    base = 4'd4;
        default: base = 4'd0;
      endcase
    end
    difficult = (n == 3'd4) || (ts && (n != 3'd0));
    if (n == 3'd0)           combo_bonus = 4'd0;
    else if (combo == 5'd0)  combo_bonus = 4'd0;
    else if (combo <= 5'd2)  combo_bonus = 4'd1;
    else if (combo <= 5'd4)  combo_bonus = 4'd2;
    else if (combo <= 5'd6)  combo_bonus = 4'd3;
    else                     combo_bonus = 4'd4;
    return base + {3'b000, difficult && b2b} + combo_bonus;
  endfunction

  // NOTE: every variable in an always_comb gets a default before any branch,
  // so that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mask_d        = mask_q & ~(PLAYFIELD_ROWS'(1) << shift_row_q);
    handshake     = (state_q == S_SHIFT) && shift_valid_q && shift_ready;
    rpt_fire      = 1'b0;
    rpt_n         = n_q;
    rpt_ts        = tspin_q;
    if (state_q == S_IDLE) begin
      // A zero-line lock is reported straight from IDLE. Its row count is zero
      // by definition and its T-spin flag comes from the input.
      rpt_fire = lock_valid && (lines_full == '0);
      rpt_n    = 3'd0;
      rpt_ts   = tspin;
    end else if (handshake && (mask_d == '0)) begin
      rpt_fire = 1'b1;
    end
    rpt_difficult = (rpt_n == 3'd4) || (rpt_ts && (rpt_n != 3'd0));
    rpt_sent      = attack(rpt_n, rpt_ts, b2b_q, combo_q);
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q           <= S_IDLE;
      mask_q            <= '0;
      tspin_q           <= 1'b0;
      n_q               <= '0;
      cnt_q             <= '0;
      busy_q            <= 1'b0;
      shift_valid_q     <= 1'b0;
      shift_row_q       <= '0;
      done_q            <= 1'b0;
      lines_this_lock_q <= '0;
      lines_sent_q      <= '0;
      combo_count_q     <= '0;
      combo_q           <= '0;
      b2b_q             <= 1'b0;
    end else if (game_start) begin
      // Abort any sequence, including a lock arriving in the same cycle.
      state_q       <= S_IDLE;
      mask_q        <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      shift_valid_q <= 1'b0;
      done_q        <= 1'b0;
      combo_count_q <= '0;
      combo_q       <= '0;
      b2b_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (lock_valid) begin
            busy_q  <= 1'b1;
            mask_q  <= lines_full;
            tspin_q <= tspin;
            n_q     <= sat_count(lines_full);
            if (lines_full != '0) begin
              state_q <= S_ANIM;
              cnt_q   <= CNT_W'(CLEAR_DELAY - 1);
            end else begin
              state_q <= S_REPORT;
            end
          end
        end

        S_ANIM: begin
          if (cnt_q == '0) begin
            state_q       <= S_SHIFT;
            shift_valid_q <= 1'b1;
            shift_row_q   <= lowest_row(mask_q);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_SHIFT: begin
          // While shift_ready is low the command is held unchanged.
          if (handshake) begin
            mask_q <= mask_d;
            if (mask_d == '0) begin
              state_q       <= S_REPORT;
              shift_valid_q <= 1'b0;
            end else begin
              shift_row_q <= lowest_row(mask_d);
            end
          end
        end

        S_REPORT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= S_IDLE;
      endcase

      if (rpt_fire) begin
        done_q            <= 1'b1;
        lines_this_lock_q <= rpt_n;
        lines_sent_q      <= rpt_sent;
        combo_count_q     <= combo_q;
        if (rpt_n != 3'd0) begin
          combo_q <= (combo_q == 5'd31) ? 5'd31 : combo_q + 5'd1;
        end else begin
          combo_q <= 5'd0;
        end
        // A zero-line lock leaves B2B alone. Any other clear either arms it
        // (difficult clear) or breaks it.
        if (rpt_difficult) begin
          b2b_q <= 1'b1;
        end else if (rpt_n != 3'd0) begin
          b2b_q <= 1'b0;
        end
      end
    end
  end

  assign busy            = busy_q;
  assign shift_valid     = shift_valid_q;
  assign shift_row       = shift_row_q;
  assign done            = done_q;
  assign lines_this_lock = lines_this_lock_q;
  assign lines_sent      = lines_sent_q;
  assign combo_count     = combo_count_q;
  assign b2b_active      = b2b_q;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Self-checking bench for line_clear_sequencer.
// The reference model keeps the combo streak and the B2B flag as plain
// integers. It derives each lock's expected rows, timing and attack directly
// from the line-clear rules.
module tb_line_clear_sequencer;

  localparam int ROWS = 20;
  localparam int CD   = 30;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic            game_start = 1'b0;
  logic            lock_valid = 1'b0;
  logic            tspin = 1'b0;
  logic [ROWS-1:0] lines_full = '0;
  logic            shift_ready = 1'b0;
  logic            busy;
  logic            shift_valid;
  logic [4:0]      shift_row;
  logic            done;
  logic [2:0]      lines_this_lock;
  logic [3:0]      lines_sent;
  logic [4:0]      combo_count;
  logic            b2b_active;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_combo = 0;
  bit m_b2b   = 1'b0;

  line_clear_sequencer #(.PLAYFIELD_ROWS(ROWS), .CLEAR_DELAY(CD)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .game_start     (game_start),
    .lock_valid     (lock_valid),
    .tspin          (tspin),
    .lines_full     (lines_full),
    .shift_ready    (shift_ready),
    .busy           (busy),
    .shift_valid    (shift_valid),
    .shift_row      (shift_row),
    .done           (done),
    .lines_this_lock(lines_this_lock),
    .lines_sent     (lines_sent),
    .combo_count    (combo_count),
    .b2b_active     (b2b_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one lock and follows it to its done pulse.
  // Observation i is the i-th sample after the lock edge; a clearing lock must
  // present its first command at i == CD.
  task automatic run_lock(input logic [ROWS-1:0] mask, input bit ts,
                          input int rdy_pct, input bit stall_req, input bit spurious);
    int  rows[$];
    int  k, n, base, cb, exp_sent, exp_combo;
    int  i, hs, low_cnt, done_i, stall_left;
    bit  difficult, got_done, stall_pending, valid_exp;

    for (int r = 0; r < ROWS; r++) if (mask[r]) rows.push_back(r);
    k         = rows.size();
    n         = (k > 4) ? 4 : k;
    if (ts)          base = 2 * n;
    else if (n == 4) base = 4;
    else if (n == 3) base = 2;
    else if (n == 2) base = 1;
    else             base = 0;
    difficult = (n == 4) || (ts && n >= 1);
    cb        = (n == 0) ? 0 : (((m_combo + 1) / 2 > 4) ? 4 : (m_combo + 1) / 2);
    exp_sent  = base + ((difficult && m_b2b) ? 1 : 0) + cb;
    exp_combo = m_combo;

    lock_valid  = 1'b1;
    lines_full  = mask;
    tspin       = ts;
    shift_ready = 1'b0;
    tick();
    lock_valid = 1'b0;
    lines_full = ROWS'($urandom);
    tspin      = 1'($urandom_range(0, 1));

    i = 0; hs = 0; low_cnt = 0; done_i = 0; stall_left = 0;
    got_done = 1'b0; stall_pending = stall_req;
    while (!got_done && i < 1000) begin
      if (done) begin
        got_done = 1'b1;
        done_i   = i;
      end else begin
        valid_exp = (i >= CD) && (rows.size() > 0);
        check("busy_during", busy, 1);
        check("shift_valid", shift_valid, valid_exp);
        if (valid_exp) check("shift_row", shift_row, rows[0]);
        if (stall_pending && hs == 1) begin
          stall_left    = 10;
          stall_pending = 1'b0;
        end
        if (stall_left > 0) begin
          shift_ready = 1'b0;
          stall_left--;
        end else begin
          shift_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        if (valid_exp) begin
          if (shift_ready) begin
            void'(rows.pop_front());
            hs++;
          end else begin
            low_cnt++;
          end
        end
        lock_valid = spurious && ($urandom_range(0, 4) == 0);
        lines_full = ROWS'($urandom);
        tick();
        i++;
      end
    end

    lock_valid  = 1'b0;
    shift_ready = 1'b0;
    if (!got_done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("done_cycle", done_i, (k == 0) ? 0 : CD + k + low_cnt);
      check("busy_at_done", busy, 1);
      check("lines_this_lock", lines_this_lock, n);
      check("lines_sent", lines_sent, exp_sent);
      check("combo_count", combo_count, exp_combo);
      m_combo = (n >= 1) ? ((m_combo >= 31) ? 31 : m_combo + 1) : 0;
      if (difficult)   m_b2b = 1'b1;
      else if (n >= 1) m_b2b = 1'b0;
      check("b2b_active", b2b_active, m_b2b);
    end
    tick();
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("sent_hold", lines_sent, exp_sent);
    check("combo_hold", combo_count, exp_combo);
  endtask

  initial begin
    logic [ROWS-1:0] m;
    bit              ts;
    bit              bad;

    // Reset, then idle.
    #12;
    check("rst_busy", busy, 0);
    check("rst_shift_valid", shift_valid, 0);
    check("rst_done", done, 0);
    check("rst_sent", lines_sent, 0);
    check("rst_combo", combo_count, 0);
    check("rst_b2b", b2b_active, 0);
    tick();
    rst_l = 1'b1;
    repeat (3) tick();
    check("idle_busy", busy, 0);

    // Zero-line lock, then rows 5 and 19 with shift_ready always high.
    run_lock('0, 1'b0, 100, 1'b0, 1'b0);
    run_lock(ROWS'((1 << 5) | (1 << 19)), 1'b0, 100, 1'b0, 1'b0);

    // Tetris, tetris (after a zero-line lock to restart the combo).
    run_lock('0, 1'b0, 100, 1'b0, 1'b0);
    run_lock(ROWS'(32'h000F_0000), 1'b0, 100, 1'b0, 1'b0);
    run_lock(ROWS'(32'h0000_00F0), 1'b0, 100, 1'b0, 1'b0);

    // Four T-spin doubles, then a T-spin triple, then a zero-line lock and a single.
    run_lock('0, 1'b0, 100, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) run_lock(ROWS'(32'h0_0003 << (2 * j)), 1'b1, 100, 1'b0, 1'b0);
    run_lock(ROWS'(32'h0_0700), 1'b1, 100, 1'b0, 1'b0);
    check("tst_sent", lines_sent, 9);
    run_lock('0, 1'b0, 100, 1'b0, 1'b0);
    run_lock(ROWS'(32'h0_0001), 1'b0, 100, 1'b0, 1'b0);

    // Ten-cycle ready stall mid-SHIFT, with lock_valid pulses while busy.
    run_lock(ROWS'(32'h4_1012), 1'b0, 100, 1'b1, 1'b1);

    // More than four rows: every row is shifted, count saturates at 4.
    run_lock(ROWS'(32'hA_0C41), 1'b0, 100, 1'b0, 1'b0);

    // Randomized locks.
    for (int j = 0; j < 30; j++) begin
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = ROWS'(1) << $urandom_range(0, ROWS - 1);
        2:       m = ROWS'($urandom) & ROWS'($urandom) & ROWS'($urandom);
        default: m = ROWS'($urandom) & ROWS'($urandom);
      endcase
      ts = 1'($urandom_range(0, 1));
      if ($countones(m) >= 4) ts = 1'b0;
      run_lock(m, ts, $urandom_range(30, 100), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Build a streak whose reported value is 3, then abort during ANIM.
    run_lock('0, 1'b0, 100, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) run_lock(ROWS'(32'h0_0001), 1'b0, 100, 1'b0, 1'b0);
    check("pre_gs_combo", combo_count, 3);
    lock_valid = 1'b1;
    lines_full = ROWS'(32'h0_0300);
    tick();
    lock_valid = 1'b0;
    repeat (5) tick();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    m_combo = 0;
    m_b2b   = 1'b0;
    check("gs_busy", busy, 0);
    check("gs_shift_valid", shift_valid, 0);
    check("gs_done", done, 0);
    check("gs_combo", combo_count, 0);
    check("gs_b2b", b2b_active, 0);
    bad = 1'b0;
    shift_ready = 1'b1;
    for (int j = 0; j < CD + 10; j++) begin
      if (shift_valid || done || busy) bad = 1'b1;
      tick();
    end
    shift_ready = 1'b0;
    check("gs_quiet", bad, 0);

    // game_start in the same cycle as a lock: the lock is dropped.
    lock_valid = 1'b1;
    game_start = 1'b1;
    lines_full = '0;
    tick();
    lock_valid = 1'b0;
    game_start = 1'b0;
    tick();
    check("gs_lock_done", done, 0);
    check("gs_lock_busy", busy, 0);

    // Asynchronous reset in the middle of SHIFT.
    lock_valid = 1'b1;
    lines_full = ROWS'(32'h0_0884);
    tspin      = 1'b0;
    tick();
    lock_valid = 1'b0;
    repeat (CD) tick();
    check("pre_rst_shift_valid", shift_valid, 1);
    #2;
    rst_l = 1'b0;
    #1;
    check("arst_shift_valid", shift_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_shift_row", shift_row, 0);
    check("arst_b2b", b2b_active, 0);
    tick();
    rst_l   = 1'b1;
    m_combo = 0;
    m_b2b   = 1'b0;
    tick();
    run_lock(ROWS'(32'h0_0001), 1'b0, 100, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_clear_sequencer.md
# line_clear_sequencer

Sequences the playfield's line-clear operation after every piece lock and computes the attack (garbage lines sent) for that lock. It samples the full-row mask at lock time, holds off for a clear-animation delay, then issues one row-collapse command per full row to the playfield storage over a valid/ready handshake. It tracks combo and back-to-back (B2B) state across locks and reports the per-lock result to the lines counter and the garbage loading bar.

## Interface
- PLAYFIELD_ROWS, 20: rows in the playfield; row 0 is the top.
- CLEAR_DELAY, 30: animation hold cycles between mask capture and the first shift; must be ≥1.
- clk  in  1  system clock.
- rst_l  in  1  reset, asynchronous, active-low.
- game_start  in  1  synchronous clear: aborts any sequence and zeroes combo/B2B state.
- lock_valid  in  1  single-cycle pulse: the active piece has locked this cycle.
- tspin  in  1  qualifies lock_valid: the lock was a T-spin.
- lines_full  in  PLAYFIELD_ROWS  one bit per row, set when the row is full; sampled only with an accepted lock_valid.
- shift_ready  in  1  playfield accepts the current shift command.
- busy  out  1  high from accepted lock until the cycle after done.
- shift_valid  out  1  shift command valid.
- shift_row  out  5  row to delete; rows 0..shift_row-1 move down one, row 0 fills empty.
- done  out  1  single-cycle pulse: per-lock results valid.
- lines_this_lock  out  3  full rows in this lock, saturated at 4.
- lines_sent  out  4  garbage lines generated by this lock.
- combo_count  out  5  consecutive clearing locks before this one, saturating at 31.
- b2b_active  out  1  last difficult-class clear armed B2B.

## Operation
- States: IDLE, ANIM, SHIFT, REPORT.
- IDLE: on lock_valid, capture lines_full into mask_q and tspin into tspin_q, and set busy.
  - Mask nonzero: go to ANIM and load the delay counter with CLEAR_DELAY-1.
  - Mask zero: go to REPORT.
- ANIM: decrement the counter each cycle. At 0, go to SHIFT.
- SHIFT: drive shift_row with the lowest-index set bit of mask_q and hold shift_valid.
  - On shift_valid && shift_ready, clear that bit.
  - If mask_q becomes zero, go to REPORT; otherwise present the next row on the following cycle.
  - Ascending order keeps the remaining indices valid, because deleting row r moves only rows above r.
- REPORT: one cycle. Pulse done, update combo and B2B, return to IDLE.
- lines_this_lock: popcount of the captured mask, min 4.
- Base attack, with n = lines_this_lock:
  - Normal clears: n=0→0, 1→0, 2→1, 3→2, 4→4.
  - T-spin clears: 0→0, 1→2, 2→4, 3→6.
- Difficult clear: n=4, or tspin with n≥1.
- B2B bonus: +1 if the clear is difficult and b2b_active was already set.
- Combo bonus is indexed by the combo_count value shown at done (the streak before this lock):
  - 0→0; 1–2→1; 3–4→2; 5–6→3; ≥7→4.
  - Applies only when n≥1.
- lines_sent is the sum of base, B2B and combo bonuses. The maximum is 6+1+4=11, which fits in 4 bits.
- State update at REPORT:
  - n≥1: combo_count increments after reporting, saturating at 31.
  - n=0: combo_count clears after reporting; b2b_active is unchanged.
  - Difficult clear: sets b2b_active.
  - Non-difficult clear with n≥1: clears b2b_active.
- lock_valid while busy is ignored. No queueing.
- Masks with more than 4 bits set: every set row is shifted; lines_this_lock saturates at 4.

## Timing
- Reset values: all outputs 0, state IDLE, mask 0, counter 0.
- game_start (any state) takes effect next cycle:
  - state IDLE, shift_valid 0, busy 0;
  - combo_count and b2b_active 0;
  - no done pulse.
- game_start coincident with lock_valid: game_start wins and the lock is dropped.
- Zero-line lock: lock at cycle t, done at t+1, busy high at t+1 only.
- Clearing lock: lock at t, ANIM covers t+1..t+CLEAR_DELAY, first shift_valid at t+CLEAR_DELAY+1.
- With shift_ready tied high, k rows take k cycles; done follows on the cycle after the last handshake.
- shift_valid and shift_row stay stable while shift_ready is low.
- lines_this_lock, lines_sent and combo_count hold their values from done until the next done. The combo_count shown is the pre-update value.

## Test plan
- Reset then idle: all outputs 0. Lock with mask 0: done one cycle later, lines_sent=0, combo_count=0.
- Rows 5 and 19 full, shift_ready=1, CLEAR_DELAY=30: shift_row=5 then 19 on consecutive cycles starting 31 cycles after lock; done with lines_this_lock=2, lines_sent=1.
- Tetris then tetris, each lock waiting for done:
  - First done: lines_sent=4, b2b_active=1.
  - Second done: lines_sent=4+1+1=6 (combo_count=1 at done), b2b_active=1.
- T-spin double on four consecutive clearing locks: 5th clearing lock (combo_count=4 at done) is a T-spin triple with b2b armed, giving lines_sent=6+1+2=9. A following zero-line lock clears the combo count; the next single reports combo_count=0.
- shift_ready low for 10 cycles mid-SHIFT: shift_row is held, no bit is lost, done is delayed exactly 10 cycles. lock_valid during busy is ignored.
- game_start asserted during ANIM with combo_count=3: next cycle IDLE, busy=0, no shift issued, combo_count=0, b2b_active=0.
- rst_l asserted low mid-SHIFT: outputs go 0 immediately (asynchronous).
